spi_transfer_controller: RTL and testbench

// - Master-mode SPI transfer sequencer behind the APB slave register block.
// - Takes the register block's send_data/mosi_data and config, and generates ss, sclk and mosi.
// - Samples miso and returns miso_data with a receive_data pulse; reports tip back to the register block.

---
 rtl/spi_ctrl_pkg.sv | 23 ++
 rtl/spi_baud_gen.sv | 42 ++++
 rtl/spi_transfer_controller.sv | 142 ++++++++++++++
 tb/tb_spi_transfer_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transfer controller.
// - spi_state_e : sequencer states.
// - SPI_RUN/SPI_WAIT : spi_mode encodings.
// - half_period() : baud half-period H = (sppr+1) * 2^spr in PCLK cycles.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StDone
  } spi_state_e;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;

  // Largest value is 8 * 2^7 = 1024, so 11 bits suffice.
  function automatic logic [10:0] half_period(input logic [2:0] spr, input logic [2:0] sppr);
    return 11'({1'b0, sppr} + 4'd1) << spr;
  endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Loadable baud down-counter.
// - clk_i, rst_i : clock, asynchronous active-high reset.
// - load_i       : restart the count at period_i-1.
// - en_i         : count while high.
// - freeze_i     : hold the count (no ticks) while high.
// - period_i     : half-period H (never 0).
// - tick_o       : one-cycle pulse every H enabled, unfrozen cycles.
module spi_baud_gen #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             freeze_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !freeze_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = period_i - CNT_W'(1);
    end else if (en_i && !freeze_i) begin
      // Reload on every tick so edges stay exactly H cycles apart.
      cnt_d = (cnt_q == '0) ? period_i - CNT_W'(1) : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_transfer_controller.sv
// Master-mode SPI transfer sequencer.
// - PCLK/PRESET : clock, asynchronous active-high reset.
// - send_data, mosi_data, mstr, cpol, cpha, lsbfe, spiswai, spi_mode, spr, sppr : request/config.
// - miso : serial input.
// - ss, sclk, mosi, tip : slave select (low), SPI clock, serial out, transfer in progress.
// - receive_data, miso_data : completion pulse and received byte (held until next completion).
module spi_transfer_controller import spi_ctrl_pkg::*; #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              send_data,
  input  logic [DATA_W-1:0] mosi_data,
  input  logic              mstr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic [2:0]        spr,
  input  logic [2:0]        sppr,
  input  logic              miso,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  output logic              tip,
  output logic              receive_data,
  output logic [DATA_W-1:0] miso_data
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W);

  spi_state_e        state_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [EdgeW-1:0]  edge_q;
  logic              cpol_q, cpha_q, lsbfe_q;
  logic [2:0]        spr_q, sppr_q;

  logic             start, freeze, tick, sample_edge;
  logic [EdgeW-1:0] edge_nr;
  logic [CNT_W-1:0] period;

  assign start  = (state_q == StIdle) && send_data && mstr;
  assign freeze = (spi_mode == SPI_WAIT) && spiswai;
  // The counter is loaded with the live selects on the start edge, latched ones afterwards.
  assign period = (state_q == StIdle) ? CNT_W'(half_period(spr, sppr))
                                      : CNT_W'(half_period(spr_q, sppr_q));
  assign edge_nr = edge_q + EdgeW'(1);
  // cpha=0 samples on odd edges, cpha=1 on even edges.
  assign sample_edge = edge_nr[0] ^ cpha_q;

  spi_baud_gen #(
    .CNT_W(CNT_W)
  ) u_baud (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .load_i  (start),
    .en_i    ((state_q == StSetup) || (state_q == StXfer) || (state_q == StHold)),
    .freeze_i(freeze),
    .period_i(period),
    .tick_o  (tick)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= StIdle;
      ss           <= 1'b1;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      tip          <= 1'b0;
      receive_data <= 1'b0;
      miso_data    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      edge_q       <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsbfe_q      <= 1'b0;
      spr_q        <= '0;
      sppr_q       <= '0;
    end else begin
      receive_data <= 1'b0;
      if (state_q == StIdle) begin
        sclk <= cpol;
        if (start) begin
          tx_q    <= mosi_data;
          cpol_q  <= cpol;
          cpha_q  <= cpha;
          lsbfe_q <= lsbfe;
          spr_q   <= spr;
          sppr_q  <= sppr;
          edge_q  <= '0;
          ss      <= 1'b0;
          tip     <= 1'b1;
          mosi    <= lsbfe ? mosi_data[0] : mosi_data[DATA_W-1];
          state_q <= StSetup;
        end
      end else if (!mstr) begin
        // Abort: drop the frame without a completion pulse.
        ss      <= 1'b1;
        tip     <= 1'b0;
        sclk    <= cpol;
        state_q <= StIdle;
      end else if (!freeze) begin
        unique case (state_q)
          StSetup: if (tick) state_q <= StXfer;
          StXfer: begin
            if (tick) begin
              edge_q <= edge_nr;
              sclk   <= (edge_nr == LastEdge) ? cpol_q : ~sclk;
              if (sample_edge) begin
                rx_q <= lsbfe_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
              end else if (edge_nr != EdgeW'(1) && edge_nr != LastEdge) begin
                // First bit was driven at start; nothing follows the last edge.
                if (lsbfe_q) begin
                  mosi <= tx_q[1];
                  tx_q <= tx_q >> 1;
                end else begin
                  mosi <= tx_q[DATA_W-2];
                  tx_q <= tx_q << 1;
                end
              end
              if (edge_nr == LastEdge) state_q <= StHold;
            end
          end
          StHold: if (tick) state_q <= StDone;
          StDone: begin
            miso_data    <= rx_q;
            receive_data <= 1'b1;
            ss           <= 1'b1;
            tip          <= 1'b0;
            state_q      <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench for spi_transfer_controller with a loopback / model slave on miso.
module tb_spi_transfer_controller;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       send_data, mstr, cpol, cpha, lsbfe, spiswai, miso;
  logic [7:0] mosi_data;
  logic [1:0] spi_mode;
  logic [2:0] spr, sppr;
  logic       ss, sclk, mosi, tip, receive_data;
  logic [7:0] miso_data;

  int errors = 0;
  int checks = 0;

  // Slave side model / frame monitor.
  logic       slave_mode = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] cap = 8'h00;
  logic       sclk_prev = 1'b0, ss_prev = 1'b1;
  int cyc = 0, edge_num = 0, rises = 0, rd_cnt = 0;
  int first_edge_cyc = 0, last_edge_cyc = 0, ss_fall_cyc = 0, ss_rise_cyc = 0;

  logic frz_bad = 1'b0, frz_sclk, frz_mosi;
  int   lat, rd0;

  assign miso = slave_mode ? slave_bit : mosi;

  always #5 PCLK = ~PCLK;

  spi_transfer_controller dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .send_data   (send_data),
    .mosi_data   (mosi_data),
    .mstr        (mstr),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsbfe       (lsbfe),
    .spiswai     (spiswai),
    .spi_mode    (spi_mode),
    .spr         (spr),
    .sppr        (sppr),
    .miso        (miso),
    .ss          (ss),
    .sclk        (sclk),
    .mosi        (mosi),
    .tip         (tip),
    .receive_data(receive_data),
    .miso_data   (miso_data)
  );

  always @(posedge PCLK) begin
    #1;
    cyc++;
    if (receive_data) rd_cnt++;
    if (ss_prev && !ss) ss_fall_cyc = cyc;
    if (!ss_prev && ss) ss_rise_cyc = cyc;
    if (ss) begin
      edge_num = 0;
    end else if (sclk != sclk_prev) begin
      edge_num++;
      if (edge_num == 1) first_edge_cyc = cyc;
      last_edge_cyc = cyc;
      if (sclk && !sclk_prev) rises++;
      if ((edge_num % 2) != int'(cpha)) cap = {cap[6:0], mosi};
      else if (slave_mode) slave_bit = slave_byte[(edge_num - 1) / 2];
    end
    ss_prev   = ss;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a frame and count PCLK edges from the start edge until receive_data is seen.
  task automatic run_frame(input int frz_at, input logic wai, input int resend_at,
                           output int lat_o);
    lat_o = -1;
    cap   = 8'h00;
    rises = 0;
    @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (receive_data) begin
        lat_o = c;
        break;
      end
      send_data = (c == resend_at);
      if (frz_at >= 0 && c == frz_at) begin
        spi_mode = 2'b01;
        spiswai  = wai;
        frz_sclk = sclk;
        frz_mosi = mosi;
      end
      if (frz_at >= 0 && c == frz_at + 20) begin
        spi_mode = 2'b00;
        spiswai  = 1'b0;
      end
      if (frz_at >= 0 && wai && c > frz_at && c <= frz_at + 20 &&
          (sclk !== frz_sclk || mosi !== frz_mosi)) frz_bad = 1'b1;
      @(negedge PCLK);
    end
    send_data = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    send_data = 1'b0; mstr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    spiswai = 1'b0; spi_mode = 2'b00; spr = 3'd0; sppr = 3'd0; mosi_data = 8'h00;
    repeat (3) @(negedge PCLK);
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_tip", tip, 1'b0);
    check("rst_rd", receive_data, 1'b0);
    check("rst_miso_data", miso_data, 8'h00);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);

    // Mode 0, MSB first, loopback.
    mosi_data = 8'hA5;
    run_frame(-1, 1'b0, -1, lat);
    check("m0_latency", lat, 19);
    check("m0_miso_data", miso_data, 8'hA5);
    check("m0_mosi_bits", cap, 8'hA5);
    check("m0_rises", rises, 8);
    @(negedge PCLK);
    check("m0_rd_width", receive_data, 1'b0);
    check("m0_ss_end", ss, 1'b1);
    check("m0_tip_end", tip, 1'b0);

    // Mode 3, LSB first, model slave returns C3.
    cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1;
    slave_mode = 1'b1; slave_byte = 8'hC3; slave_bit = 1'b0;
    repeat (2) @(negedge PCLK);
    check("m3_sclk_idle", sclk, 1'b1);
    mosi_data = 8'h3C;
    run_frame(-1, 1'b0, -1, lat);
    check("m3_latency", lat, 19);
    check("m3_miso_data", miso_data, 8'hC3);
    check("m3_mosi_bits", cap, 8'h3C);
    check("m3_sclk_end", sclk, 1'b1);
    slave_mode = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    repeat (2) @(negedge PCLK);

    // H = 6.
    sppr = 3'd2; spr = 3'd1; mosi_data = 8'h5A;
    run_frame(-1, 1'b0, -1, lat);
    check("h6_latency", lat, 109);
    check("h6_ss_low", ss_rise_cyc - ss_fall_cyc, 109);
    check("h6_edge_span", last_edge_cyc - first_edge_cyc, 90);
    check("h6_miso_data", miso_data, 8'h5A);
    sppr = 3'd0; spr = 3'd0;

    // Freeze for 20 cycles mid-transfer, then the same with spiswai low.
    mosi_data = 8'h96;
    run_frame(6, 1'b1, -1, lat);
    check("frz_latency", lat, 39);
    check("frz_held", frz_bad, 1'b0);
    check("frz_miso_data", miso_data, 8'h96);
    run_frame(6, 1'b0, -1, lat);
    check("nofrz_latency", lat, 19);

    // Start request during a frame is dropped.
    mosi_data = 8'h0F;
    rd0 = rd_cnt;
    run_frame(-1, 1'b0, 5, lat);
    check("resend_latency", lat, 19);
    repeat (40) @(negedge PCLK);
    check("resend_single", rd_cnt - rd0, 1);
    check("resend_ss_idle", ss, 1'b1);
    check("resend_miso_data", miso_data, 8'h0F);

    // Master disabled: no frame.
    mstr = 1'b0;
    @(negedge PCLK); send_data = 1'b1;
    @(negedge PCLK); send_data = 1'b0;
    repeat (3) @(negedge PCLK);
    check("nomstr_ss", ss, 1'b1);
    check("nomstr_tip", tip, 1'b0);
    mstr = 1'b1;

    // mstr dropped mid-transfer.
    mosi_data = 8'hFF;
    rd0 = rd_cnt;
    @(negedge PCLK); send_data = 1'b1;
    @(negedge PCLK); send_data = 1'b0;
    repeat (6) @(negedge PCLK);
    check("abort_in_frame", tip, 1'b1);
    mstr = 1'b0;
    @(negedge PCLK);
    check("abort_ss", ss, 1'b1);
    check("abort_tip", tip, 1'b0);
    check("abort_sclk", sclk, 1'b0);
    mstr = 1'b1;
    repeat (30) @(negedge PCLK);
    check("abort_no_rd", rd_cnt - rd0, 0);
    check("abort_miso_data", miso_data, 8'h0F);

    // Asynchronous reset at the 5th sclk edge.
    mosi_data = 8'hC3;
    rd0 = rd_cnt;
    @(negedge PCLK); send_data = 1'b1;
    @(negedge PCLK); send_data = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (edge_num >= 5) break;
      @(negedge PCLK);
    end
    check("prst_edge5", edge_num, 5);
    #2 PRESET = 1'b1;
    #1;
    check("prst_ss", ss, 1'b1);
    check("prst_sclk", sclk, 1'b0);
    check("prst_mosi", mosi, 1'b0);
    check("prst_tip", tip, 1'b0);
    check("prst_miso_data", miso_data, 8'h00);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (40) @(negedge PCLK);
    check("prst_no_rd", rd_cnt - rd0, 0);
    check("prst_ss_idle", ss, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
